// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan path: segment encodings (a..g, dp in bit0)
// and the default digit count.
package seg_pkg;
  localparam int NUM_DIGITS = 3;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;

  typedef enum logic {PH_BLANK, PH_DRIVE} scan_phase_e;
endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit counters for the scan: frame_done marks the last cycle of a frame,
// blank marks the anti-ghosting gap at the start of each digit slot.
module seg_scan_timer #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 4,
  parameter int GHOST_CYC  = 1,
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             frame_done_o,
  output logic             blank_o
);
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              slot_wrap, idx_wrap;

  assign slot_wrap = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign idx_wrap  = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign frame_done_o = slot_wrap && idx_wrap;

  // A zero-length gap would make the compare constant, so elide it.
  generate
    if (GHOST_CYC == 0) begin : g_no_ghost
      assign blank_o = 1'b0;
    end else begin : g_ghost
      assign blank_o = (slot_q < SLOT_W'(GHOST_CYC));
    end
  endgenerate
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit 7-segment driver with frame-boundary shadow reload.
// Optional: define SCAN_DIM_EN to add a dim input that blanks every other frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int GHOST_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg0,
  input  logic [7:0]            seg1,
  input  logic [7:0]            seg2,
  input  logic                  ld,
`ifdef SCAN_DIM_EN
  input  logic                  dim,
`endif
  output logic                  ld_ack,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0][7:0] seg_in, shadow_q, shadow_d;
  logic                       pending_q, pending_d;
  logic                       ld_ack_q, ld_ack_d;
  logic [IDX_W-1:0]           idx;
  logic                       blank, force_blank, reload;
  scan_phase_e                phase;

  assign seg_in = {seg2, seg1, seg0};

  seg_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .GHOST_CYC (GHOST_CYC)
  ) u_timer (
    .clk_i       (clk),
    .rst_i       (rst),
    .idx_o       (idx),
    .frame_done_o(frame_done),
    .blank_o     (blank)
  );

  // A request on the boundary cycle itself is honoured at that same edge.
  assign reload = frame_done && (pending_q || ld);

  always_comb begin
    shadow_d  = reload ? seg_in : shadow_q;
    ld_ack_d  = reload;
    pending_d = frame_done ? 1'b0 : (pending_q || ld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ld_ack_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ld_ack_q  <= ld_ack_d;
    end
  end

`ifdef SCAN_DIM_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst)             parity_q <= 1'b0;
    else if (frame_done) parity_q <= ~parity_q;
  end

  assign force_blank = dim && parity_q;
`else
  assign force_blank = 1'b0;
`endif

  assign phase  = (blank || force_blank) ? PH_BLANK : PH_DRIVE;
  assign ld_ack = ld_ack_q;

  always_comb begin
    seg_out = SEG_BLANK;
    dig_en  = '0;
    if (phase == PH_DRIVE) begin
      dig_en  = NUM_DIGITS'(1) << idx;
      seg_out = shadow_q[idx];
    end
  end
endmodule
